// File: rtl/pkt_out_arbiter_rr.sv
// rtl/pkt_out_arbiter_rr.sv - N-input round-robin packet arbiter with ctrl tagging, output FIFO and counters
// Whole packets are granted in turn; words are tagged and queued toward the output queue stage.
module pkt_out_arbiter_rr #(
  parameter int NUM_INPUTS       = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int CTRL_WIDTH       = 8,
  parameter int FIFO_AW          = 4,
  parameter int PROG_FULL_THRESH = 12
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_wr,
  input  logic [NUM_INPUTS-1:0]            in_req,
  output logic [NUM_INPUTS-1:0]            in_ack,
  input  logic [NUM_INPUTS-1:0]            in_bop,
  input  logic [NUM_INPUTS-1:0]            in_eop,
  output logic [NUM_INPUTS-1:0]            in_outrdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [31:0]                      pkt_cnt,
  output logic [15:0]                      drop_cnt
);
  localparam int GW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic {S_IDLE, S_TX} state_e;

  state_e                  state_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           rr_ptr_q;
  logic [GW-1:0]           rr_ptr_d;
  logic [NUM_INPUTS-1:0]   in_ack_q;
  logic [FW-1:0]           fifo_mem_q [DEPTH];
  logic [FIFO_AW-1:0]      wr_ptr_q;
  logic [FIFO_AW-1:0]      rd_ptr_q;
  logic [FIFO_AW:0]        usedw_q;
  logic [FIFO_AW:0]        usedw_d;
  logic                    out_wr_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q;
  logic [31:0]             pkt_cnt_q;
  logic [31:0]             pkt_cnt_d;
  logic [15:0]             drop_cnt_q;
  logic [15:0]             drop_cnt_d;

  logic                    pick_found;
  logic [GW-1:0]           pick_idx;
  logic [GW:0]             scan_sum;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    g_wr;
  logic                    g_bop;
  logic                    g_eop;
  logic                    is_tx;
  logic [NUM_INPUTS-1:0]   gnt_oh;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    prog_full;
  logic                    fifo_rd;
  logic                    fifo_wr;
  logic                    pkt_end;
  logic [CTRL_WIDTH-1:0]   ctrl_sel;
  logic [NUM_INPUTS-1:0]   drop_vec;
  logic [15:0]             drop_add;
  logic [16:0]             drop_sum;

  // Round-robin scan: first requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (scan_sum >= (GW+1)'(NUM_INPUTS)) scan_sum = scan_sum - (GW+1)'(NUM_INPUTS);
      if (!pick_found && in_req[scan_sum[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_q == GW'(i)) g_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_wr       = in_wr[grant_q];
  assign g_bop      = in_bop[grant_q];
  assign g_eop      = in_eop[grant_q];
  assign is_tx      = (state_q == S_TX);
  assign gnt_oh     = is_tx ? (NUM_INPUTS'(1) << grant_q) : '0;
  assign fifo_empty = (usedw_q == '0);
  assign fifo_full  = (usedw_q == (FIFO_AW+1)'(DEPTH));
  assign prog_full  = (usedw_q >= (FIFO_AW+1)'(PROG_FULL_THRESH));
  assign fifo_rd    = ~fifo_empty & out_rdy;
  // A full FIFO still takes the write when a pop frees a slot on the same edge.
  assign fifo_wr    = is_tx & g_wr & (~fifo_full | fifo_rd);
  assign pkt_end    = is_tx & g_wr & g_eop;
  assign ctrl_sel   = g_bop ? CTRL_WIDTH'(8'hFF) : (g_eop ? CTRL_WIDTH'(1) : '0);
  assign in_outrdy  = gnt_oh & {NUM_INPUTS{~prog_full}};
  assign rr_ptr_d   = (grant_q == GW'(NUM_INPUTS-1)) ? '0 : grant_q + GW'(1);

  assign drop_vec = is_tx ? ((in_wr & ~gnt_oh) | (in_wr & gnt_oh & {NUM_INPUTS{~fifo_wr}}))
                          : in_wr;

  always_comb begin
    drop_add = '0;
    for (int i = 0; i < NUM_INPUTS; i++) drop_add = drop_add + 16'(drop_vec[i]);
  end

  assign drop_sum   = {1'b0, drop_cnt_q} + {1'b0, drop_add};
  assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  assign pkt_cnt_d  = pkt_cnt_q + 32'(fifo_wr & g_eop);

  always_comb begin
    usedw_d = usedw_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   usedw_d = usedw_q + (FIFO_AW+1)'(1);
      2'b01:   usedw_d = usedw_q - (FIFO_AW+1)'(1);
      default: usedw_d = usedw_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      in_ack_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_q  <= pick_idx;
            in_ack_q <= NUM_INPUTS'(1) << pick_idx;
            state_q  <= S_TX;
          end
        end
        S_TX: begin
          if (pkt_end) begin
            in_ack_q <= '0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= {ctrl_sel, g_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usedw_q    <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      usedw_q    <= usedw_d;
      out_wr_q   <= fifo_rd;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (fifo_rd) begin
        rd_ptr_q                 <= rd_ptr_q + FIFO_AW'(1);
        {out_ctrl_q, out_data_q} <= fifo_mem_q[rd_ptr_q];
      end
    end
  end

  assign in_ack   = in_ack_q;
  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule
